// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spart_pkg
// Description : Shared constants and state types for the SPART UART block.
// Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

    // Bus register select codes
    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    // Baud divisors for a 50 MHz clock with 16x oversampling
    localparam logic [15:0] DB_4800  = 16'd650;
    localparam logic [15:0] DB_9600  = 16'd325;
    localparam logic [15:0] DB_19200 = 16'd162;
    localparam logic [15:0] DB_38400 = 16'd80;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : spart_baud_gen
// Description : Programmable divisor registers and down counter producing a
//               one-cycle baud tick every DB+1 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET = DB_9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_lo,
    input  logic       i_wr_hi,
    input  logic [7:0] i_wdata,
    output logic       o_tick
);

    logic [15:0] r_db;
    logic [15:0] r_cnt;
    logic [15:0] w_db_next;

    always_comb begin
        w_db_next = r_db;
        if (i_wr_lo) begin
            w_db_next = {r_db[15:8], i_wdata};
        end else if (i_wr_hi) begin
            w_db_next = {i_wdata, r_db[7:0]};
        end
    end

    // A divisor write restarts the count so the new rate takes effect at once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db  <= DB_RESET;
            r_cnt <= DB_RESET;
        end else begin
            r_db <= w_db_next;
            if (i_wr_lo || i_wr_hi) begin
                r_cnt <= w_db_next;
            end else if (r_cnt == 16'd0) begin
                r_cnt <= r_db;
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign o_tick = (r_cnt == 16'd0);

endmodule : spart_baud_gen
`default_nettype wire

// File: rtl/spart_unit.sv
`default_nettype none
// ============================================================================
// Module      : spart_unit
// Description : 8N1 UART with 8-bit bidirectional bus interface, independent
//               full-duplex TX/RX engines and programmable baud generator.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_unit
    import spart_pkg::*;
#(
    parameter int          CLK_HZ     = 50000000,
    parameter int          OVERSAMPLE = 16,
    parameter logic [15:0] DB_RESET   = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam int                c_tcnt_w = $clog2(OVERSAMPLE);
    localparam logic [c_tcnt_w-1:0] c_last = c_tcnt_w'(OVERSAMPLE - 1);
    localparam logic [c_tcnt_w-1:0] c_mid  = c_tcnt_w'(OVERSAMPLE / 2 - 1);

    if (CLK_HZ < 1 || OVERSAMPLE < 2) begin : g_bad_params
        $error("spart_unit: CLK_HZ and OVERSAMPLE must be positive");
    end

    // ------------------------------------------------------------------ bus
    logic       w_wr;
    logic       w_rd;
    logic       w_tx_load;
    logic       w_rd_buf;
    logic [7:0] w_rd_data;
    logic [7:0] r_rx_buf;
    logic       r_rda;
    logic       w_tick;

    assign w_wr      = iocs && !iorw;
    assign w_rd      = iocs && iorw;
    assign w_tx_load = w_wr && (ioaddr == ADDR_BUF) && tbr;
    assign w_rd_buf  = w_rd && (ioaddr == ADDR_BUF);

    always_comb begin
        w_rd_data = 8'h00;
        case (ioaddr)
            ADDR_BUF:    w_rd_data = r_rx_buf;
            ADDR_STATUS: w_rd_data = {6'b0, tbr, r_rda};
            default:     w_rd_data = 8'h00;
        endcase
    end

    assign databus = w_rd ? w_rd_data : 8'hzz;
    assign rda     = r_rda;

    spart_baud_gen #(
        .DB_RESET (DB_RESET)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .i_wr_lo (w_wr && (ioaddr == ADDR_DBL)),
        .i_wr_hi (w_wr && (ioaddr == ADDR_DBH)),
        .i_wdata (databus),
        .o_tick  (w_tick)
    );

    // ------------------------------------------------------------ transmit
    tx_state_t           r_tx_state;
    tx_state_t           w_tx_next;
    logic [c_tcnt_w-1:0] r_tx_tcnt;
    logic [2:0]          r_tx_bit;
    logic [7:0]          r_tx_shift;
    logic                w_tx_bit_end;

    assign w_tx_bit_end = w_tick && (r_tx_tcnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_tx_load) w_tx_next = TX_START;
            TX_START: if (w_tx_bit_end) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_bit_end) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tbr = 1'b0;
        txd = 1'b1;
        case (r_tx_state)
            TX_IDLE:  tbr = 1'b1;
            TX_START: txd = 1'b0;
            TX_DATA:  txd = r_tx_shift[0];
            default:  txd = 1'b1;
        endcase
    end

    // Tick counter restarts on every state change so each bit is a full 16 ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_tcnt  <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
        end else begin
            if (w_tx_next != r_tx_state) begin
                r_tx_tcnt <= '0;
            end else if (w_tick) begin
                r_tx_tcnt <= r_tx_tcnt + 1'b1;
            end
            if (w_tx_load) begin
                r_tx_shift <= databus;
            end else if (r_tx_state == TX_DATA && w_tx_bit_end) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
            if (r_tx_state != TX_DATA) begin
                r_tx_bit <= 3'd0;
            end else if (w_tx_bit_end) begin
                r_tx_bit <= r_tx_bit + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------- receive
    rx_state_t           r_rx_state;
    rx_state_t           w_rx_next;
    logic                r_rx_s1;
    logic                r_rx_s2;
    logic                r_rx_prev;
    logic [c_tcnt_w-1:0] r_rx_tcnt;
    logic [2:0]          r_rx_bit;
    logic [7:0]          r_rx_shift;
    logic                w_rx_fall;
    logic                w_rx_bit_end;
    logic                w_rx_sample;
    logic                w_rx_done;

    assign w_rx_fall    = r_rx_prev && !r_rx_s2;
    assign w_rx_bit_end = w_tick && (r_rx_tcnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // A framing error drops straight to IDLE; a new start needs a fresh falling edge
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_tick && r_rx_tcnt == c_mid)
                          w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_bit_end && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_bit_end) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_sample = 1'b0;
        w_rx_done   = 1'b0;
        case (r_rx_state)
            RX_DATA: w_rx_sample = w_rx_bit_end;
            RX_STOP: w_rx_done   = w_rx_bit_end && r_rx_s2;
            default: w_rx_sample = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_tcnt  <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_buf   <= 8'h00;
            r_rda      <= 1'b0;
        end else begin
            r_rx_s1   <= rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (w_rx_next != r_rx_state) begin
                r_rx_tcnt <= '0;
            end else if (w_tick) begin
                r_rx_tcnt <= r_rx_tcnt + 1'b1;
            end
            if (r_rx_state != RX_DATA) begin
                r_rx_bit <= 3'd0;
            end else if (w_rx_sample) begin
                r_rx_bit <= r_rx_bit + 3'd1;
            end
            if (w_rx_sample) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            end
            // A completing byte wins over a same-cycle buffer read
            if (w_rx_done) begin
                r_rx_buf <= r_rx_shift;
                r_rda    <= 1'b1;
            end else if (w_rd_buf) begin
                r_rda <= 1'b0;
            end
        end
    end

endmodule : spart_unit
`default_nettype wire

// File: tb/tb_spart_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_spart_unit
// Description : Directed self-checking bench for spart_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_unit;

    logic       clk;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rxd;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       drv_en;
    logic [7:0] drv_data;
    tri1  [7:0] databus;

    int checks   = 0;
    int failures = 0;

    assign databus = drv_en ? drv_data : 8'hzz;

    spart_unit dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_en = 1'b1; drv_data = d;
        @(posedge clk); #1;
        iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(posedge clk); #1;
        iocs = 1'b0;
    endtask

    task automatic rx_bit(input logic b);
        rxd = b;
        repeat (32) @(posedge clk);
        #1;
    endtask

    task automatic rx_start_data(input logic [7:0] d);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
    endtask

    // Called right after the write that started the frame; 'already' counts
    // clocks that have passed since that write edge.
    task automatic tx_expect(input string tag, input logic [7:0] d, input int already);
        logic [9:0] frame;
        int         n;
        frame = {1'b1, d, 1'b0};
        n = already;
        repeat (15 - already) @(posedge clk);
        #1;
        n = 15;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                repeat (32) @(posedge clk);
                #1;
                n += 32;
            end
            check($sformatf("%s_bit%0d", tag, k), 32'(txd), 32'(frame[k]));
        end
        while (!tbr && n < 700) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_tbr_cycles_in_window"}, 32'(n >= 316 && n <= 324), 32'd1);
    endtask

    logic [7:0] rd;
    int         n;

    initial begin
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        rxd = 1'b1; drv_en = 1'b0; drv_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_tbr", 32'(tbr), 32'd1);
        check("reset_rda", 32'(rda), 32'd0);
        check("reset_bus_released", 32'(databus), 32'hFF);
        bus_read(2'b01, rd);
        check("reset_status", 32'(rd), 32'h02);
        bus_read(2'b10, rd);
        check("read_dbl_zero", 32'(rd), 32'h00);

        // Transmit 0xA6 at DB=1 (32 clocks per bit)
        bus_write(2'b10, 8'h01);
        bus_write(2'b11, 8'h00);
        bus_write(2'b00, 8'hA6);
        check("tx_tbr_low_after_write", 32'(tbr), 32'd0);
        tx_expect("txA6", 8'hA6, 0);

        // Receive 0x59
        rx_start_data(8'h59);
        check("rx59_rda_before_stop", 32'(rda), 32'd0);
        rx_bit(1'b1);
        check("rx59_rda_set", 32'(rda), 32'd1);
        bus_read(2'b01, rd);
        check("rx59_status", 32'(rd), 32'h03);
        bus_read(2'b00, rd);
        check("rx59_data", 32'(rd), 32'h59);
        check("rx59_rda_cleared", 32'(rda), 32'd0);

        // Glitch on rxd: false start
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check("glitch_no_rda", 32'(rda), 32'd0);

        // Framing error then a good frame
        rx_start_data(8'h3C);
        rx_bit(1'b0);
        rx_bit(1'b1);
        rx_bit(1'b1);
        check("framing_no_rda", 32'(rda), 32'd0);
        rx_start_data(8'hC3);
        rx_bit(1'b1);
        check("rxC3_rda_set", 32'(rda), 32'd1);
        bus_read(2'b00, rd);
        check("rxC3_data", 32'(rd), 32'hC3);

        // Busy write: second byte must be dropped
        bus_write(2'b00, 8'h11);
        bus_write(2'b00, 8'h22);
        tx_expect("busy11", 8'h11, 1);

        // Reset in the middle of a frame
        bus_write(2'b00, 8'h5A);
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_txd", 32'(txd), 32'd1);
        check("midreset_tbr", 32'(tbr), 32'd1);
        rst = 1'b0;

        // Reset divisor 325: one data bit is 16*326 clocks
        bus_write(2'b00, 8'h55);
        n = 0;
        while (txd !== 1'b1 && n < 7000) begin
            @(posedge clk); #1;
            n++;
        end
        check("db325_start_end_seen", 32'(txd), 32'd1);
        n = 0;
        while (txd !== 1'b0 && n < 7000) begin
            @(posedge clk); #1;
            n++;
        end
        check("db325_bit_width", 32'(n), 32'd5216);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spart_unit
`default_nettype wire
